// File: rtl/mem_dma_pkg.sv
// Shared types and widths for the memory copy/fill DMA engine.
package mem_dma_pkg;

    localparam int DMA_AW = 8;
    localparam int DMA_DW = 8;

    typedef enum logic {
        OP_COPY = 1'b0,
        OP_FILL = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_dma_ptr.sv
// Loadable wrapping address up-counter used for the source and destination pointers.
module mem_dma_ptr
    import mem_dma_pkg::*;
#(
    parameter int AW = DMA_AW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] ptr_r;

    // Load has priority; increment wraps naturally at 2**AW.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= {AW{1'b0}};
        end else if (load) begin
            ptr_r <= load_val;
        end else if (inc) begin
            ptr_r <= ptr_r + ONE_AW;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/mem_dma_engine.sv
// Bus-master copy/fill engine for the 8-bit data memory port.
// Optional running checksum of written bytes when MEM_DMA_CHECKSUM_EN is defined.
module mem_dma_engine
    import mem_dma_pkg::*;
#(
    parameter int AW = DMA_AW,
    parameter int DW = DMA_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  op_e           op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] remaining,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);

    localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_r;
    op_e           op_r;
    logic [DW-1:0] fill_r;
    logic [DW-1:0] rd_buf_r;
    logic [AW-1:0] remaining_r;
    logic          busy_r;
    logic          done_r;
    logic          req_r;
    logic [AW-1:0] src_ptr_s;
    logic [AW-1:0] dst_ptr_s;
    logic          accept_s;
    logic          read_ok_s;
    logic          write_ok_s;

    // Qualify accesses: abort suppresses any transfer in the cycle it is seen.
    always_comb begin
        accept_s   = (state_r == S_IDLE) && start;
        read_ok_s  = (state_r == S_READ) && mem_gnt && !abort;
        write_ok_s = (state_r == S_WRITE) && mem_gnt && !abort;
    end

    mem_dma_ptr #(.AW(AW)) u_src_ptr (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept_s),
        .load_val (src),
        .inc      (read_ok_s),
        .ptr      (src_ptr_s)
    );

    mem_dma_ptr #(.AW(AW)) u_dst_ptr (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (accept_s),
        .load_val (dst),
        .inc      (write_ok_s),
        .ptr      (dst_ptr_s)
    );

    // Command FSM with registered status outputs and the remaining-bytes down-counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            op_r        <= OP_COPY;
            fill_r      <= {DW{1'b0}};
            rd_buf_r    <= {DW{1'b0}};
            remaining_r <= {AW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            req_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r        <= op;
                        fill_r      <= fill_val;
                        remaining_r <= len;
                        busy_r      <= 1'b1;
                        if (len == {AW{1'b0}}) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            req_r   <= 1'b0;
                        end else begin
                            state_r <= (op == OP_FILL) ? S_WRITE : S_READ;
                            done_r  <= 1'b0;
                            req_r   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (abort) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        req_r   <= 1'b0;
                    end else if (mem_gnt) begin
                        rd_buf_r <= mem_rdata;
                        state_r  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        req_r   <= 1'b0;
                    end else if (mem_gnt) begin
                        remaining_r <= remaining_r - ONE_AW;
                        if (remaining_r == ONE_AW) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            req_r   <= 1'b0;
                        end else begin
                            state_r <= (op_r == OP_COPY) ? S_READ : S_WRITE;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    req_r   <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // Memory port steering; address and data park at zero outside READ/WRITE.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        case (state_r)
            S_READ: begin
                mem_addr = src_ptr_s;
            end
            S_WRITE: begin
                mem_addr  = dst_ptr_s;
                mem_wdata = (op_r == OP_COPY) ? rd_buf_r : fill_r;
            end
            default: begin
                mem_addr  = {AW{1'b0}};
                mem_wdata = {DW{1'b0}};
            end
        endcase
    end

    assign mem_we    = write_ok_s;
    assign mem_req   = req_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign remaining = remaining_r;

`ifdef MEM_DMA_CHECKSUM_EN
    logic [DW-1:0] csum_r;

    // Sum of committed write data, restarted on every accepted command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_r <= {DW{1'b0}};
        end else if (accept_s) begin
            csum_r <= {DW{1'b0}};
        end else if (write_ok_s) begin
            csum_r <= csum_r + mem_wdata;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign csum = csum_r;
`endif

endmodule

// File: tb/tb_mem_dma_engine.sv
// Self-checking bench for mem_dma_engine: directed vector table plus randomized commands
// against a byte-array reference memory. Checksum port checked when MEM_DMA_CHECKSUM_EN is defined.
module tb_mem_dma_engine;
    import mem_dma_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    op_e        op;
    logic [7:0] src, dst, len, fill_val;
    logic       abort;
    logic       busy, done;
    logic [7:0] remaining;
    logic       mem_req, mem_gnt, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [7:0] csum;
`endif

    always #5 clock = ~clock;

    mem_dma_engine dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
`ifdef MEM_DMA_CHECKSUM_EN
        , .csum    (csum)
`endif
    );

    // Behavioural memory plus access monitors (counters never reset; tasks use deltas).
    logic [7:0] mem      [256];
    logic [7:0] init_img [256];
    logic [7:0] ref_mem  [256];
    logic       init_mem;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         req_cnt = 0;
    int         rd_log [4096];

    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
        end else begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_req && mem_gnt && !mem_we) begin
                rd_log[rd_cnt % 4096] <= int'(mem_addr);
                rd_cnt <= rd_cnt + 1;
            end
            if (mem_req) req_cnt <= req_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        op_e        op;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] fill;
        int         stall_at;
        int         stall_len;
        int         abort_at;
        int         busy_start_at;
        int         exp_lat;
        int         exp_rem;
        int         exp_writes;
    } vec_t;

    vec_t vecs [6];

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v, input bit rand_gnt, input string tag);
        int         base_wr, base_rd, base_req, lat, mism;
        logic [7:0] d;
        logic [7:0] exp_csum;
        @(negedge clock);
        op = v.op; src = v.src; dst = v.dst; len = v.len; fill_val = v.fill;
        start = 1'b1; abort = 1'b0; mem_gnt = 1'b1;
        base_wr = wr_cnt; base_rd = rd_cnt; base_req = req_cnt;
        lat = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clock);
            if (done) begin
                lat = c;
                check({tag, "_remaining"}, remaining, v.exp_rem);
            end
            start = (c == v.busy_start_at);
            if (start) begin
                op = OP_FILL; dst = 8'hC0; len = 8'h04; fill_val = 8'h5A;
            end
            abort = (lat == 0) && (c == v.abort_at);
            if (lat != 0) mem_gnt = 1'b1;
            else if (rand_gnt) mem_gnt = ($urandom_range(3, 0) != 0);
            else mem_gnt = !((c >= v.stall_at) && (c < v.stall_at + v.stall_len));
            #1;
            if (!mem_gnt && busy && !done) check({tag, "_stall_we"}, mem_we, 1'b0);
            if (lat != 0) break;
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            abort = 1'b0; start = 1'b0;
            do_reset();
        end
        @(negedge clock);
        start = 1'b0;
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_done_pulse"}, done, 1'b0);
        if (v.exp_lat != 0) check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_writes"}, wr_cnt - base_wr, v.exp_writes);
        if (v.len == 8'd0) check({tag, "_no_req"}, req_cnt - base_req, 0);

        // Reference: byte-by-byte forward transfer on a wrapping 256-byte array.
        exp_csum = 8'h00;
        for (int i = 0; i < v.exp_writes; i++) begin
            d = (v.op == OP_COPY) ? ref_mem[8'(v.src + 8'(i))] : v.fill;
            ref_mem[8'(v.dst + 8'(i))] = d;
            exp_csum = exp_csum + d;
        end
`ifdef MEM_DMA_CHECKSUM_EN
        check({tag, "_csum"}, csum, exp_csum);
`endif
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check({tag, "_mem"}, mism, 0);

        if (v.op == OP_COPY && v.abort_at == 0) begin
            check({tag, "_read_cnt"}, rd_cnt - base_rd, v.len);
            mism = 0;
            for (int i = 0; i < int'(v.len); i++)
                if (rd_log[(base_rd + i) % 4096] != int'(8'(v.src + 8'(i)))) mism++;
            check({tag, "_read_order"}, mism, 0);
        end
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0; start = 1'b0; op = OP_COPY; src = 8'h00; dst = 8'h00;
        len = 8'h00; fill_val = 8'h00; abort = 1'b0; mem_gnt = 1'b1;
        for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
        init_img[8'h20] = 8'h11; init_img[8'h21] = 8'h22; init_img[8'h22] = 8'h33;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_img[i];
        init_mem = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        init_mem = 1'b0;
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_remaining", remaining, 8'h00);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
`ifdef MEM_DMA_CHECKSUM_EN
        check("rst_csum",      csum,      8'h00);
`endif
        reset_n = 1'b1;

        //          op       src    dst    len    fill   stl stln abrt bsy lat rem wr
        vecs[0] = '{OP_FILL, 8'h00, 8'h10, 8'd4, 8'hA5, 0, 0, 0, 0, 5, 0, 4};
        vecs[1] = '{OP_COPY, 8'h20, 8'h40, 8'd3, 8'h00, 0, 0, 0, 2, 7, 0, 3};
        vecs[2] = '{OP_COPY, 8'hFE, 8'h80, 8'd4, 8'h00, 0, 0, 0, 0, 9, 0, 4};
        vecs[3] = '{OP_FILL, 8'h00, 8'h70, 8'd0, 8'hEE, 0, 0, 0, 1, 1, 0, 0};
        vecs[4] = '{OP_FILL, 8'h00, 8'h90, 8'd3, 8'h3C, 2, 2, 0, 0, 6, 0, 3};
        vecs[5] = '{OP_COPY, 8'h50, 8'hA0, 8'd5, 8'h00, 0, 0, 4, 0, 5, 4, 1};

        for (int t = 0; t < 6; t++) run_cmd(vecs[t], 1'b0, $sformatf("t%0d", t + 1));

        `ifdef MEM_DMA_CHECKSUM_EN
        `endif

        for (int r = 0; r < 20; r++) begin
            v.op        = op_e'($urandom_range(1, 0));
            v.src       = 8'($urandom);
            v.dst       = 8'($urandom);
            v.len       = 8'($urandom_range(24, 0));
            v.fill      = 8'($urandom);
            v.stall_at  = 0; v.stall_len = 0; v.abort_at = 0;
            v.busy_start_at = (r % 3 == 0) ? 2 : 0;
            v.exp_rem   = 0;
            v.exp_writes = int'(v.len);
            if (r >= 10) v.exp_lat = 0;
            else if (v.len == 8'd0) v.exp_lat = 1;
            else if (v.op == OP_COPY) v.exp_lat = 2 * int'(v.len) + 1;
            else v.exp_lat = int'(v.len) + 1;
            run_cmd(v, r >= 10, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
